// File: rtl/vec_addr_gen.sv
// vec_addr_gen: strided vector load/store address generator.
// Splits a vector memory instruction into bus-aligned beats and packs every
// element that lands in the same bus word into a single beat.
// Optional feature macro: VAG_MISALIGN_CHECK_EN rejects base/stride values
// that are not element-aligned; without it, element addresses are forced
// down to element alignment instead.
module vec_addr_gen #(
  parameter  int BUS_BYTES = 4,
  parameter  int VLMAX     = 32,
  localparam int VL_W      = $clog2(VLMAX + 1),
  localparam int CNT_W     = $clog2(BUS_BYTES + 1),
  localparam int OFF_W     = $clog2(4 * VLMAX),
  localparam int LB        = $clog2(BUS_BYTES)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 start_i,
  input  logic [31:0]          base_addr_i,
  input  logic [31:0]          stride_i,
  input  logic [VL_W-1:0]      vl_i,
  input  logic [1:0]           vsew_i,
  output logic                 ready_o,
  output logic                 req_valid_o,
  input  logic                 req_ready_i,
  output logic [31:0]          req_addr_o,
  output logic [BUS_BYTES-1:0] req_be_o,
  output logic [VL_W-1:0]      req_el_idx_o,
  output logic [CNT_W-1:0]     req_el_cnt_o,
  output logic [OFF_W-1:0]     vd_offset_o,
  output logic                 req_last_o,
  output logic                 done_o,
  output logic                 err_o
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_t          r_state;
  logic [31:0]     r_cur_addr;
  logic [31:0]     r_stride;
  logic [VL_W-1:0] r_vl;
  logic [VL_W-1:0] r_idx;
  logic [1:0]      r_vsew;
  logic            r_err;

  logic                 w_issue;
  logic                 w_stride_zero;
  logic [CNT_W-1:0]     w_pack_cnt;
  logic [CNT_W-1:0]     w_cnt;
  logic [BUS_BYTES-1:0] w_be;
  logic [BUS_BYTES-1:0] w_elem_mask;
  logic [LB-1:0]        w_lane_mask;
  logic                 w_last;
  logic [31:0]          w_next_addr;
  logic [VL_W-1:0]      w_vl_clamped;

  assign w_issue       = (r_state == S_ISSUE);
  assign w_stride_zero = (r_stride == 32'd0);
  assign w_vl_clamped  = (vl_i > VL_W'(VLMAX)) ? VL_W'(VLMAX) : vl_i;

  // Byte mask of one element and the lane bits kept for element alignment.
  always_comb begin
    // NOTE: every signal assigned in always_comb gets a default first so no
    // path leaves it unassigned, which would infer a latch.
    w_elem_mask = BUS_BYTES'(4'b1111);
    w_lane_mask = '1;
    case (r_vsew)
      2'b00: w_elem_mask = BUS_BYTES'(4'b0001);
      2'b01: begin
        w_elem_mask = BUS_BYTES'(4'b0011);
`ifndef VAG_MISALIGN_CHECK_EN
        w_lane_mask = ~LB'(1);
`endif
      end
      default: begin
        w_elem_mask = BUS_BYTES'(4'b1111);
`ifndef VAG_MISALIGN_CHECK_EN
        w_lane_mask = ~LB'(3);
`endif
      end
    endcase
  end

  // Pack consecutive candidates that stay in the current bus word.
  always_comb begin : pack_calc
    logic        run;
    logic [31:0] a_j;
    run        = 1'b1;
    a_j        = '0;
    w_pack_cnt = '0;
    w_be       = '0;
    for (int j = 0; j < BUS_BYTES; j++) begin
      a_j = r_cur_addr + 32'(j) * r_stride;
      run = run
          && ((32'(r_idx) + 32'(j)) < 32'(r_vl))
          && (a_j[31:LB] == r_cur_addr[31:LB])
          && ((j == 0) || !w_stride_zero);
      if (run) begin
        w_pack_cnt = w_pack_cnt + CNT_W'(1);
        w_be       = w_be | (w_elem_mask << (a_j[LB-1:0] & w_lane_mask));
      end
    end
  end

  // Stride 0 reports the whole vector length in one beat, saturated.
  assign w_cnt = w_stride_zero ? ((32'(r_vl) > 32'(CNT_MAX)) ? CNT_MAX : CNT_W'(r_vl))
                               : w_pack_cnt;
  assign w_last      = w_stride_zero || ((32'(r_idx) + 32'(w_cnt)) >= 32'(r_vl));
  assign w_next_addr = r_cur_addr + 32'(w_cnt) * r_stride;

  // Beat outputs are only driven while issuing so idle values stay zero.
  assign ready_o      = (r_state == S_IDLE);
  assign req_valid_o  = w_issue;
  assign req_addr_o   = w_issue ? {r_cur_addr[31:LB], {LB{1'b0}}} : '0;
  assign req_be_o     = w_issue ? w_be : '0;
  assign req_el_idx_o = w_issue ? r_idx : '0;
  assign req_el_cnt_o = w_issue ? w_cnt : '0;
  assign vd_offset_o  = w_issue ? (OFF_W'(r_idx) << r_vsew) : '0;
  assign req_last_o   = w_issue && w_last;
  assign done_o       = (r_state == S_DONE);
  assign err_o        = (r_state == S_DONE) && r_err;

`ifdef VAG_MISALIGN_CHECK_EN
  logic w_misalign;
  always_comb begin
    w_misalign = 1'b0;
    case (vsew_i)
      2'b01:   w_misalign = base_addr_i[0] | stride_i[0];
      2'b10:   w_misalign = (|base_addr_i[1:0]) | (|stride_i[1:0]);
      default: w_misalign = 1'b0;
    endcase
  end
`endif

  // Control FSM: accepts an instruction, walks its beats, signals completion.
  always_ff @(posedge clk_i) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (rst_i) begin
      r_state    <= S_IDLE;
      r_cur_addr <= '0;
      r_stride   <= '0;
      r_vl       <= '0;
      r_idx      <= '0;
      r_vsew     <= '0;
      r_err      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_err <= 1'b0;
          if (start_i) begin
            r_cur_addr <= base_addr_i;
            r_stride   <= stride_i;
            r_vl       <= w_vl_clamped;
            r_vsew     <= vsew_i;
            r_idx      <= '0;
            if (vsew_i == 2'b11) begin
              r_err   <= 1'b1;
              r_state <= S_DONE;
            end else if (w_vl_clamped == '0) begin
              r_state <= S_DONE;
`ifdef VAG_MISALIGN_CHECK_EN
            end else if (w_misalign) begin
              r_err   <= 1'b1;
              r_state <= S_DONE;
`endif
            end else begin
              r_state <= S_ISSUE;
            end
          end
        end
        S_ISSUE: begin
          if (req_ready_i) begin
            if (w_last) begin
              r_state <= S_DONE;
            end else begin
              r_idx      <= r_idx + VL_W'(w_cnt);
              r_cur_addr <= w_next_addr;
            end
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vec_addr_gen.sv
// tb_vec_addr_gen: directed and randomized checks of vec_addr_gen against a
// per-element reference model of the beat packing rules.
module tb_vec_addr_gen;

  localparam int BB      = 4;
  localparam int VLMAX   = 32;
  localparam int VL_W    = $clog2(VLMAX + 1);
  localparam int CNT_W   = $clog2(BB + 1);
  localparam int OFF_W   = $clog2(4 * VLMAX);
  localparam int LB      = $clog2(BB);
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic              clk_i = 1'b0;
  logic              rst_i = 1'b1;
  logic              start_i = 1'b0;
  logic [31:0]       base_addr_i = '0;
  logic [31:0]       stride_i = '0;
  logic [VL_W-1:0]   vl_i = '0;
  logic [1:0]        vsew_i = '0;
  logic              ready_o;
  logic              req_valid_o;
  logic              req_ready_i = 1'b0;
  logic [31:0]       req_addr_o;
  logic [BB-1:0]     req_be_o;
  logic [VL_W-1:0]   req_el_idx_o;
  logic [CNT_W-1:0]  req_el_cnt_o;
  logic [OFF_W-1:0]  vd_offset_o;
  logic              req_last_o;
  logic              done_o;
  logic              err_o;

  vec_addr_gen #(.BUS_BYTES(BB), .VLMAX(VLMAX)) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .start_i      (start_i),
    .base_addr_i  (base_addr_i),
    .stride_i     (stride_i),
    .vl_i         (vl_i),
    .vsew_i       (vsew_i),
    .ready_o      (ready_o),
    .req_valid_o  (req_valid_o),
    .req_ready_i  (req_ready_i),
    .req_addr_o   (req_addr_o),
    .req_be_o     (req_be_o),
    .req_el_idx_o (req_el_idx_o),
    .req_el_cnt_o (req_el_cnt_o),
    .vd_offset_o  (vd_offset_o),
    .req_last_o   (req_last_o),
    .done_o       (done_o),
    .err_o        (err_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [31:0]   addr;
    logic [BB-1:0] be;
    int            idx;
    int            cnt;
    int            off;
    bit            last;
  } beat_t;

  beat_t exp_q[$];
  bit    exp_reject;
  bit    exp_err;
  int    n_checks = 0;
  int    n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference model: walk the elements in order, starting a new beat whenever
  // an element leaves the word of the beat's first element or the beat is full.
  task automatic build_model(input logic [31:0] base, input logic [31:0] stride,
                             input int vl_raw, input logic [1:0] vsew);
    int          vl;
    int          es;
    int          k;
    int          n;
    logic [31:0] amask;
    logic [31:0] e;
    logic [31:0] w0;
    logic [31:0] ea;
    logic [BB-1:0] be;
    exp_q.delete();
    exp_reject = 0;
    exp_err    = 0;
    vl    = (vl_raw > VLMAX) ? VLMAX : vl_raw;
    es    = 1 << vsew;
    amask = ~(32'(es) - 32'd1);
    if (vsew == 2'b11) begin
      exp_reject = 1; exp_err = 1; return;
    end
    if (vl == 0) begin
      exp_reject = 1; return;
    end
`ifdef VAG_MISALIGN_CHECK_EN
    if (((base | stride) & ~amask) != 32'd0) begin
      exp_reject = 1; exp_err = 1; return;
    end
`endif
    if (stride == 32'd0) begin
      ea = base & amask;
      be = BB'((1 << es) - 1) << (ea & 32'(BB - 1));
      exp_q.push_back('{(base >> LB) << LB, be, 0, (vl > CNT_MAX) ? CNT_MAX : vl, 0, 1'b1});
      return;
    end
    k = 0;
    while (k < vl) begin
      w0 = base + 32'(k) * stride;
      n  = 0;
      be = '0;
      e  = w0;
      while ((n < BB) && (k + n < vl) && ((e >> LB) == (w0 >> LB))) begin
        ea = e & amask;
        be = be | (BB'((1 << es) - 1) << (ea & 32'(BB - 1)));
        n++;
        e = base + 32'(k + n) * stride;
      end
      exp_q.push_back('{(w0 >> LB) << LB, be, k, n, k << vsew, (k + n) >= vl});
      k = k + n;
    end
  endtask

  // Synchronous reset pulse; checks the idle/reset output state afterwards.
  task automatic do_reset(input string tag);
    rst_i       = 1'b1;
    start_i     = 1'b0;
    req_ready_i = 1'b0;
    @(negedge clk_i);
    check({tag, "_valid"}, 32'(req_valid_o), 32'd0);
    check({tag, "_ready"}, 32'(ready_o), 32'd1);
    check({tag, "_done"}, 32'(done_o), 32'd0);
    check({tag, "_err"}, 32'(err_o), 32'd0);
    check({tag, "_last"}, 32'(req_last_o), 32'd0);
    check({tag, "_addr"}, req_addr_o, 32'd0);
    check({tag, "_be"}, 32'(req_be_o), 32'd0);
    check({tag, "_idx"}, 32'(req_el_idx_o), 32'd0);
    check({tag, "_cnt"}, 32'(req_el_cnt_o), 32'd0);
    check({tag, "_off"}, 32'(vd_offset_o), 32'd0);
    rst_i = 1'b0;
    @(negedge clk_i);
    check({tag, "_nodone"}, 32'(done_o), 32'd0);
  endtask

  // mode 0: always ready; 1: random ready plus start noise; 2: stall first beat 3 cycles.
  // abort_at >= 0 resets the block while that beat is being presented.
  task automatic run_instr(input logic [31:0] base, input logic [31:0] stride,
                           input int vl, input logic [1:0] vsew,
                           input int mode, input int abort_at);
    beat_t b;
    int    stalls;
    int    beat_no;
    bit    rdy;
    build_model(base, stride, vl, vsew);
    @(negedge clk_i);
    check("idle_ready", 32'(ready_o), 32'd1);
    start_i     = 1'b1;
    base_addr_i = base;
    stride_i    = stride;
    vl_i        = VL_W'(vl);
    vsew_i      = vsew;
    @(negedge clk_i);
    start_i = 1'b0;
    if (exp_reject) begin
      check("rej_done", 32'(done_o), 32'd1);
      check("rej_err", 32'(err_o), 32'(exp_err));
      check("rej_valid", 32'(req_valid_o), 32'd0);
      @(negedge clk_i);
      check("rej_ready", 32'(ready_o), 32'd1);
      check("rej_done_low", 32'(done_o), 32'd0);
      return;
    end
    beat_no = 0;
    while (exp_q.size() > 0) begin
      b      = exp_q.pop_front();
      stalls = 0;
      forever begin
        check("valid", 32'(req_valid_o), 32'd1);
        if (req_valid_o !== 1'b1) begin
          do_reset("recover");
          return;
        end
        check("addr", req_addr_o, b.addr);
        check("be", 32'(req_be_o), 32'(b.be));
        check("idx", 32'(req_el_idx_o), 32'(b.idx));
        check("cnt", 32'(req_el_cnt_o), 32'(b.cnt));
        check("off", 32'(vd_offset_o), 32'(b.off));
        check("last", 32'(req_last_o), 32'(b.last));
        check("busy_ready", 32'(ready_o), 32'd0);
        check("busy_done", 32'(done_o), 32'd0);
        if (beat_no == abort_at) begin
          do_reset("abort");
          return;
        end
        case (mode)
          1:       rdy = ($urandom_range(0, 2) != 0) || (stalls >= 3);
          2:       rdy = (beat_no != 0) || (stalls >= 3);
          default: rdy = 1'b1;
        endcase
        req_ready_i = rdy;
        if (mode == 1) begin
          start_i     = 1'($urandom);
          base_addr_i = $urandom;
          stride_i    = $urandom;
          vl_i        = VL_W'($urandom);
          vsew_i      = 2'($urandom);
        end
        @(negedge clk_i);
        if (rdy) break;
        stalls++;
      end
      beat_no++;
    end
    req_ready_i = 1'b0;
    start_i     = 1'b0;
    check("fin_done", 32'(done_o), 32'd1);
    check("fin_err", 32'(err_o), 32'd0);
    check("fin_valid", 32'(req_valid_o), 32'd0);
    check("fin_ready_low", 32'(ready_o), 32'd0);
    @(negedge clk_i);
    check("fin_ready", 32'(ready_o), 32'd1);
    check("fin_done_low", 32'(done_o), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] r_base;
    logic [31:0] r_stride;
    logic [1:0]  r_vsew;
    int          r_vl;
    int          sel;

    rst_i = 1'b1;
    repeat (2) @(negedge clk_i);
    check("rst_ready", 32'(ready_o), 32'd1);
    check("rst_valid", 32'(req_valid_o), 32'd0);
    check("rst_last", 32'(req_last_o), 32'd0);
    check("rst_done", 32'(done_o), 32'd0);
    check("rst_err", 32'(err_o), 32'd0);
    check("rst_addr", req_addr_o, 32'd0);
    check("rst_be", 32'(req_be_o), 32'd0);
    check("rst_cnt", 32'(req_el_cnt_o), 32'd0);
    rst_i = 1'b0;

    // Directed scenarios.
    run_instr(32'h0000_1001, 32'd1,          6,  2'b00, 0, -1);
    run_instr(32'h0000_1001, 32'd1,          6,  2'b00, 2, -1);
    run_instr(32'h0000_2000, 32'd6,          3,  2'b01, 0, -1);
    run_instr(32'h0000_3000, 32'd0,          5,  2'b10, 0, -1);
    run_instr(32'h0000_4003, 32'hFFFF_FFFF,  4,  2'b00, 0, -1);
    run_instr(32'h0000_5002, 32'd4,          1,  2'b10, 0, -1);
    run_instr(32'h0000_6000, 32'd4,          3,  2'b11, 0, -1);
    run_instr(32'h0000_6100, 32'd1,          0,  2'b00, 0, -1);
    run_instr(32'h0000_7000, 32'd4,          50, 2'b10, 0, -1);
    run_instr(32'h0000_8000, 32'd0,          20, 2'b00, 0, -1);
    run_instr(32'h0000_9002, 32'hFFFF_FFFE,  9,  2'b01, 1, -1);
    run_instr(32'h0000_1001, 32'd1,          6,  2'b00, 0, 0);
    run_instr(32'h0000_1001, 32'd1,          6,  2'b00, 0, -1);

    // Randomized instructions.
    for (int i = 0; i < 60; i++) begin
      r_vsew = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      r_base = $urandom;
      if ($urandom_range(0, 1) == 0) r_base = r_base & ~(32'd1 << r_vsew) & ~32'd1;
      sel = $urandom_range(0, 5);
      case (sel)
        0:       r_stride = 32'd0;
        1:       r_stride = $urandom;
        default: r_stride = 32'($urandom_range(0, 18)) - 32'd9;
      endcase
      r_vl = $urandom_range(0, 40);
      run_instr(r_base, r_stride, r_vl, r_vsew, (i % 3 == 0) ? 0 : 1, -1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/vec_addr_gen.md
# vec_addr_gen

Parametrised strided vector load/store address generator. It sits between the vector decode/control stage and the data-memory port. For each vector memory instruction it emits a sequence of bus-aligned beats, each carrying an address, byte enables, the first element index and element count, and the destination-register byte offset. It packs every element that falls in the same bus word into one beat. It generalises the earlier 32-bit-only, positive-stride unit to configurable bus width and vector length, signed strides, and a valid/ready handshake.

## Interface
Parameters:
- BUS_BYTES, 4: data-bus width in bytes; power of two, 4 or 8.
- VLMAX, 32: maximum vector length in elements.

Derived widths:
- VL_W = $clog2(VLMAX+1)
- CNT_W = $clog2(BUS_BYTES+1)
- OFF_W = $clog2(4*VLMAX)
- LB = $clog2(BUS_BYTES)

Ports:
- clk_i  in  1  clock. The block uses this single clock only; reset is synchronous and active-high.
- rst_i  in  1  synchronous active-high reset.
- start_i  in  1  launch an instruction; sampled only in IDLE.
- base_addr_i  in  32  byte address of element 0.
- stride_i  in  32  signed byte stride.
- vl_i  in  VL_W  element count; values above VLMAX are clamped to VLMAX.
- vsew_i  in  2  element size: 00 = 8-bit, 01 = 16-bit, 10 = 32-bit, 11 = reserved.
- ready_o  out  1  block is idle and accepts start_i.
- req_valid_o  out  1  beat is valid.
- req_ready_i  in  1  memory port accepts the beat.
- req_addr_o  out  32  bus-aligned address, low LB bits zero.
- req_be_o  out  BUS_BYTES  byte enables.
- req_el_idx_o  out  VL_W  index of the first element in the beat.
- req_el_cnt_o  out  CNT_W  number of elements in the beat.
- vd_offset_o  out  OFF_W  req_el_idx_o << vsew, the byte offset into the destination register.
- req_last_o  out  1  final beat of the instruction.
- done_o  out  1  one-cycle completion pulse.
- err_o  out  1  one-cycle pulse, coincident with done_o, when the instruction is rejected.

## Operation
State machine: IDLE, ISSUE, DONE.
- **IDLE:** ready_o=1. On start_i, latch base, stride, vl and vsew, and set idx=0 and cur_addr=base.
  - vsew=11 or clamped vl=0: go to DONE (err_o is raised for vsew=11 only).
  - Alignment failure under the macro (see Configuration): go to DONE with err_o.
  - Otherwise go to ISSUE.
- **ISSUE:** req_valid_o=1. Beat contents are computed combinationally from cur_addr and idx.
  - Candidate j (0..BUS_BYTES-1) has address a_j = cur_addr + j*stride, computed in 32 bits with wrap-around modulo 2^32.
  - Candidate j belongs to the beat if all of the following hold:
    - idx+j < vl;
    - a_j[31:LB] == cur_addr[31:LB];
    - all candidates below j belong to the beat;
    - j==0 or stride != 0.
  - req_el_cnt_o is the number of members, which is always at least 1.
  - req_be_o is the OR over members of each element's bytes: (1<<esize)-1 shifted to a_j[LB-1:0].
  - Stride 0: one beat. req_el_cnt_o = vl (saturated to the CNT_W range; the consumer uses vl). req_be_o covers one element. This beat is always last.
  - Negative strides pack identically, so elements can be at descending lanes.
  - req_last_o is asserted when idx + cnt >= vl, or when stride = 0.
  - On req_valid_o && req_ready_i:
    - last beat: go to DONE;
    - otherwise: idx += cnt, cur_addr = a_cnt, and stay in ISSUE.
- **DONE:** done_o=1 (plus err_o if flagged), then go to IDLE.
- start_i outside IDLE is ignored.
- rst_i in any state forces IDLE on the next edge. No done_o is produced for the aborted instruction.

## Timing
- Reset values: req_valid_o, req_last_o, done_o and err_o are 0; idx, cur_addr and the output buses are 0; ready_o is 1, since the block is in IDLE.
- start_i accepted at edge t: req_valid_o is high in cycle t+1.
- Rejected start at t: done_o and err_o are high in cycle t+1, and req_valid_o is never asserted.
- While req_valid_o && !req_ready_i, every req_* output is held stable.
- Back-to-back beats: one beat per cycle when req_ready_i is held high.
- Final accept at edge t: done_o is high in t+1, and ready_o is high in t+2.
- All outputs are registered state or combinational functions of registered state only. There are no paths from start_i, base_addr_i, stride_i, vl_i or vsew_i to outputs.

## Configuration
- VAG_MISALIGN_CHECK_EN defined:
  - At start, base_addr_i or stride_i not a multiple of the element size (vsew 01: bit 0; vsew 10: bits 1:0) is rejected via DONE with err_o.
- VAG_MISALIGN_CHECK_EN undefined:
  - No check is made, and err_o is raised only for vsew=11.
  - Each a_j has its low element-size bits forced to zero before byte-enable generation and packing.

## Test plan
- BUS_BYTES=4, vsew 00, base 0x1001, stride 1, vl 6 -> two beats:
  - beat 1: 0x1000, be 1110, idx 0, cnt 3, off 0;
  - beat 2: 0x1004, be 0111, idx 3, cnt 3, off 3, last;
  - then done_o.
- vsew 01, base 0x2000, stride 6, vl 3 -> three beats:
  - 0x2000 be 0011 off 0;
  - 0x2004 be 1100 off 2;
  - 0x200C be 0011 off 4, last.
- vsew 10, base 0x3000, stride 0, vl 5 -> single beat 0x3000, be 1111, cnt 5, last; then done_o; ready_o two cycles after the accept.
- vsew 00, base 0x4003, stride -1 (0xFFFFFFFF), vl 4 -> single beat 0x4000, be 1111, cnt 4, idx 0.
- Scenario 1 with req_ready_i low for 3 cycles -> beat 1 held bit-stable. Separately, rst_i asserted mid-ISSUE -> next cycle req_valid_o=0 and ready_o=1, with no done_o.
- vsew 10, base 0x5002:
  - with VAG_MISALIGN_CHECK_EN: no req_valid_o, and done_o with err_o at t+1;
  - without: beat 0x5000, be 1111.
  - vsew 11 -> err_o in both builds.
